// File: rtl/restoring_divider_4bit.sv
// 4-bit unsigned restoring divider: one quotient bit per CALC cycle, a 3-state FSM,
// and a registered result with a divide-by-zero flag.

module addsub_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_sub,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [3:0] w_b;
    logic [4:0] w_full;

    always_comb begin
        w_b    = i_b ^ {4{i_sub}};
        w_full = {1'b0, i_a} + {1'b0, w_b} + {4'b0, i_sub};
    end

    assign o_sum  = w_full[3:0];
    assign o_cout = w_full[4];
endmodule

module restoring_divider_4bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_rem;
    logic [3:0] r_q;
    logic [3:0] r_d;
    logic [1:0] r_cnt;
    logic [3:0] w_rs;
    logic [3:0] w_diff;
    logic       w_cout;
    logic [3:0] w_rem_next;

    // R stays 4 bits wide: before the last shift it holds at most 3 dividend bits.
    assign w_rs = {r_rem[2:0], r_q[3]};

    addsub_4bit u_sub (
        .i_a    (w_rs),
        .i_b    (r_d),
        .i_sub  (1'b1),
        .o_sum  (w_diff),
        .o_cout (w_cout)
    );

    assign w_rem_next = w_cout ? w_diff : w_rs;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = (divisor == 4'd0) ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (r_cnt == 2'd3) w_next = DONE;
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem       <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (divisor == 4'd0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            r_rem <= '0;
                            r_q   <= dividend;
                            r_d   <= divisor;
                            r_cnt <= '0;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[2:0], w_cout};
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        quotient    <= {r_q[2:0], w_cout};
                        remainder   <= w_rem_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_restoring_divider_4bit.sv
// Self-checking bench for restoring_divider_4bit: directed cases, start/reset
// interaction and an exhaustive back-to-back sweep against integer / and %.

module tb_restoring_divider_4bit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] sb_q[$];

    restoring_divider_4bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b);
        int unsigned ai;
        int unsigned bi;
        ai = a;
        bi = b;
        if (bi == 0) return {4'hF, a, 1'b1};
        return {4'(ai / bi), 4'(ai % bi), 1'b0};
    endfunction

    // Drives one start pulse, scrambles operands once accepted, then waits (bounded) for done.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [8:0] exp_v,
                          output int lat, output int busy_n, output logic [8:0] obs);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb_q.push_back(exp_v);
        lat    = -1;
        busy_n = 0;
        obs    = 'x;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start    = 1'b0;
                dividend = ~a;
                divisor  = ~b;
            end
            if (busy) busy_n++;
            if (done) begin
                lat = i;
                obs = {quotient, remainder, div_by_zero};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd3;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({quotient, remainder, div_by_zero, busy, done} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {quotient, remainder, div_by_zero, busy, done}, 11'b0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_directed();
        logic [3:0] ta[5]   = '{4'd13, 4'd15, 4'd5, 4'd15, 4'd14};
        logic [3:0] tb[5]   = '{4'd3,  4'd1,  4'd7, 4'd15, 4'd0};
        logic [8:0] tex[5]  = '{{4'd4, 4'd1, 1'b0}, {4'd15, 4'd0, 1'b0}, {4'd0, 4'd5, 1'b0},
                                {4'd1, 4'd0, 1'b0}, {4'd15, 4'd14, 1'b1}};
        int         tlat[5] = '{5, 5, 5, 5, 1};
        int lat, busy_n;
        logic [8:0] obs, exp_v;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], tex[i], lat, busy_n, obs);
            exp_v = sb_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL directed_result %0d/%0d: got %h expected %h", ta[i], tb[i], obs, exp_v);
            end
            n_checks++;
            if (lat !== tlat[i]) begin
                n_fail++;
                $display("FAIL directed_latency %0d/%0d: got %0d expected %0d", ta[i], tb[i], lat, tlat[i]);
            end
            n_checks++;
            if (busy_n !== tlat[i]) begin
                n_fail++;
                $display("FAIL directed_busy %0d/%0d: got %0d expected %0d", ta[i], tb[i], busy_n, tlat[i]);
            end
            @(negedge clk);
            n_checks++;
            if ({done, busy, quotient, remainder, div_by_zero} !== {2'b00, exp_v}) begin
                n_fail++;
                $display("FAIL directed_hold %0d/%0d: got %h expected %h", ta[i], tb[i],
                         {done, busy, quotient, remainder, div_by_zero}, {2'b00, exp_v});
            end
        end
    endtask

    task automatic test_ignore_start();
        int n_done = 0;
        int lat = -1;
        logic [8:0] obs = 'x;
        logic [8:0] exp_v;
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        sb_q.push_back({4'd4, 4'd1, 1'b0});
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            // Retry 9/2 once mid-CALC and again while DONE is showing; both must be dropped.
            start = (i == 2) || (done === 1'b1);
            if (start) begin
                dividend = 4'd9;
                divisor  = 4'd2;
            end
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 1) begin
                    lat = i;
                    obs = {quotient, remainder, div_by_zero};
                end
            end
        end
        start = 1'b0;
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL ignore_result: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL ignore_done_count: got %0d expected 1", n_done);
        end
        n_checks++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d expected 5", lat);
        end
        n_checks++;
        if ({busy, quotient, remainder, div_by_zero} !== {1'b0, exp_v}) begin
            n_fail++;
            $display("FAIL ignore_hold: got %h expected %h",
                     {busy, quotient, remainder, div_by_zero}, {1'b0, exp_v});
        end
    endtask

    task automatic test_reset_abort();
        int n_done = 0;
        int lat, busy_n;
        logic [8:0] obs, exp_v;
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({quotient, remainder, div_by_zero, busy, done} !== 11'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: got %b expected %b",
                     {quotient, remainder, div_by_zero, busy, done}, 11'b0);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done !== 1'b0) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d expected 0", n_done);
        end
        run_op(4'd12, 4'd5, {4'd2, 4'd2, 1'b0}, lat, busy_n, obs);
        exp_v = sb_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL abort_followup: got %h expected %h", obs, exp_v);
        end
        n_checks++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL abort_followup_latency: got %0d expected 5", lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, busy_n, exp_lat;
        logic [8:0] obs, exp_v;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b), model(4'(a), 4'(b)), lat, busy_n, obs);
                exp_v   = sb_q.pop_front();
                exp_lat = (b == 0) ? 1 : 5;
                n_checks++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL sweep_result %0d/%0d: got %h expected %h", a, b, obs, exp_v);
                end
                n_checks++;
                if (lat !== exp_lat) begin
                    n_fail++;
                    $display("FAIL sweep_latency %0d/%0d: got %0d expected %0d", a, b, lat, exp_lat);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/restoring_divider_4bit.md
RESTORING_DIVIDER_4BIT -- requirements
Module: restoring_divider_4bit

Interface
REQ-001 The block SHALL have no parameters; all operand and result widths are fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 dividend  input  4  unsigned dividend, captured when start is accepted.
REQ-006 divisor  input  4  unsigned divisor, captured when start is accepted.
REQ-007 quotient  output  4  registered quotient.
REQ-008 remainder  output  4  registered remainder.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 div_by_zero  output  1  registered flag; valid while done=1, held until next accepted start.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-013 In IDLE with start=1 and divisor!=0, the block SHALL load R=0, Q=dividend, D=divisor, step count=0, and move to CALC.
REQ-014 In IDLE with start=1 and divisor==0, the block SHALL move directly to DONE with quotient=4'hF, remainder=dividend, div_by_zero=1.
REQ-015 Each CALC cycle SHALL perform one restoring step: shift {R,Q} left by 1 (Q LSB=0); compute T = R - D with the team's 4-bit adder/subtractor in subtract mode (cin=1, b=D).
REQ-016 If the subtractor cout=1 (no borrow), the block SHALL set R=T and Q[0]=1; otherwise it SHALL keep the shifted R and Q[0]=0.
REQ-017 After the 4th CALC step, the block SHALL register quotient=Q, remainder=R, div_by_zero=0, and move to DONE.
REQ-018 R SHALL never exceed 4 bits: R<D holds before every shift, and at most 3 dividend bits are shifted in before the final step.
REQ-019 done SHALL be 1 only in DONE; DONE SHALL last exactly one cycle and then return to IDLE.
REQ-020 Latency, non-zero divisor: with start sampled at edge k, done SHALL be high during the cycle after edge k+4.
REQ-021 Latency, zero divisor: done SHALL be high during the cycle after edge k.
REQ-022 start SHALL be ignored in CALC and DONE; no queuing.
REQ-023 dividend and divisor changes after acceptance SHALL NOT affect the running operation.
REQ-024 quotient, remainder and div_by_zero SHALL hold their last values until the next DONE.
REQ-025 A new start SHALL be accepted in the first IDLE cycle after DONE, giving back-to-back throughput of one result per 6 cycles.

Reset
REQ-026 With rst_n=0 at a rising edge, the block SHALL force IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0.
REQ-027 rst_n SHALL take priority over start.
REQ-028 Reset during CALC or DONE SHALL abort the operation with no done pulse; reset has no asynchronous effect.

Verification
REQ-029 13/3: start -> done 4 cycles later; quotient=4, remainder=1, div_by_zero=0, busy high for 5 cycles.
REQ-030 15/1 -> quotient=15, remainder=0; 5/7 -> quotient=0, remainder=5; 15/15 -> quotient=1, remainder=0.
REQ-031 14/0 -> done in the next cycle; quotient=15, remainder=14, div_by_zero=1.
REQ-032 Re-assert start with 9/2 during CALC of 13/3 -> ignored; result is 4/1, and a single done pulse is observed.
REQ-033 rst_n=0 for one edge during the 2nd CALC cycle -> all outputs 0, no done; a following 12/5 yields quotient=2, remainder=2.
REQ-034 Exhaustive sweep of all 256 operand pairs, back-to-back -> every result matches the integer / and % model.
